axi_slave_mem_responder: RTL and testbench



---
 rtl/axi_mem_pkg.sv | 34 +++
 rtl/axi_mem_if.sv | 73 +++++++
 rtl/axi_mem_burst_addr.sv | 72 +++++++
 rtl/axi_slave_mem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_axi_slave_mem_responder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_pkg.sv
// Shared encodings and FSM state types for the AXI memory responder.
// Burst/response codes plus a burst legality helper.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_WAIT,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // WRAP and the reserved type run as INCR but answer SLVERR
  function automatic logic burst_bad(
    input logic [1:0] burst,
    input logic [2:0] size
  );
    return burst == BURST_WRAP
        || burst == 2'b11
        || size != 3'd2;
  endfunction

endpackage

// File: rtl/axi_mem_if.sv
// AXI4 channel bundle between the bridge slave port and the memory.
// The master side drives requests, the slave side answers.
interface axi_mem_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
);

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awid, awlen,
    output awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen,
    output arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen,
    input  awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen,
    input  arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready
  );

endinterface

// File: rtl/axi_mem_burst_addr.sv
// Burst address/beat tracker shared by the read and write paths.
// AHEAD=1 exposes the next beat (read prefetch), else the current one.
module axi_mem_burst_addr
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter bit AHEAD     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         advance,
  input  logic [ADDR_W-1:0]            addr_in,
  input  logic [7:0]                   len_in,
  input  logic [1:0]                   burst_in,
  input  logic [2:0]                   size_in,
  output logic [$clog2(MEM_DEPTH)-1:0] idx,
  output logic                         oor,
  output logic                         bad,
  output logic                         last
);

  localparam int MW = $clog2(MEM_DEPTH);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] look;
  logic [7:0]        beat_q;
  logic [7:0]        len_q;
  logic              bad_q;
  logic              fixed_q;

  assign step = fixed_q ? addr_q
                        : addr_q + ADDR_W'(4);

  // latch burst on address handshake, step per beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      bad_q   <= 1'b0;
      fixed_q <= 1'b0;
    end else if (load) begin
      addr_q  <= addr_in;
      beat_q  <= '0;
      len_q   <= len_in;
      bad_q   <= burst_bad(burst_in, size_in);
      fixed_q <= burst_in == BURST_FIXED;
    end else if (advance) begin
      addr_q  <= step;
      beat_q  <= beat_q + 8'd1;
    end
  end

  // beat view: incoming request while loading, else current/next
  always_comb begin
    look = AHEAD ? step : addr_q;
    bad  = bad_q;
    last = AHEAD ? (beat_q + 8'd1 == len_q)
                 : (beat_q == len_q);
    if (load) begin
      look = addr_in;
      bad  = burst_bad(burst_in, size_in);
      last = len_in == 8'd0;
    end
    oor = look[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_DEPTH);
    idx = look[MW+1:2];
  end

endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI4 memory target for the bridge slave port: one burst per direction.
// Word memory with byte lanes; R/B responses flag range/legality errors.
module axi_slave_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 256,
  parameter int B_LAT     = 0
) (
  input  logic        s_clk_wr,
  input  logic        s_rst_wr_n,
  axi_mem_if.slave    bus,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        err_wlast
);

  localparam int MW = $clog2(MEM_DEPTH);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic              up;
  logic [3:0]        lat;
  logic              b_bad;
  logic [ID_W-1:0]   bid_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;

  logic aw_hs, w_hs, b_hs;
  logic ar_hs, r_hs, r_ld;

  logic [MW-1:0] w_idx, r_idx;
  logic          w_oor, w_bad, w_last;
  logic          r_oor, r_bad, r_last;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign b_hs  = bus.bvalid && bus.bready;
  assign ar_hs = bus.arvalid && bus.arready;
  assign r_hs  = bus.rvalid && bus.rready;
  assign r_ld  = ar_hs || (r_hs && !rlast_q);

  assign bus.bresp = b_bad ? RESP_SLVERR : RESP_OKAY;
  assign bus.bid   = bid_q;
  assign bus.rdata = rdata_q;
  assign bus.rresp = rresp_q;
  assign bus.rid   = rid_q;
  assign bus.rlast = rlast_q;

  axi_mem_burst_addr #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .AHEAD     (1'b0)
  ) u_wr_addr (
    .clk      (s_clk_wr),
    .rst_n    (s_rst_wr_n),
    .load     (aw_hs),
    .advance  (w_hs),
    .addr_in  (bus.awaddr),
    .len_in   (bus.awlen),
    .burst_in (bus.awburst),
    .size_in  (bus.awsize),
    .idx      (w_idx),
    .oor      (w_oor),
    .bad      (w_bad),
    .last     (w_last)
  );

  axi_mem_burst_addr #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .AHEAD     (1'b1)
  ) u_rd_addr (
    .clk      (s_clk_wr),
    .rst_n    (s_rst_wr_n),
    .load     (ar_hs),
    .advance  (r_hs && !rlast_q),
    .addr_in  (bus.araddr),
    .len_in   (bus.arlen),
    .burst_in (bus.arburst),
    .size_in  (bus.arsize),
    .idx      (r_idx),
    .oor      (r_oor),
    .bad      (r_bad),
    .last     (r_last)
  );

  // holds address readies low until the first clock out of reset
  always_ff @(posedge s_clk_wr or negedge s_rst_wr_n) begin
    if (!s_rst_wr_n) up <= 1'b0;
    else             up <= 1'b1;
  end

  // write FSM next state and handshake outputs
  always_comb begin
    w_next      = w_state;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        bus.awready = up;
        if (bus.awvalid && up) w_next = W_DATA;
      end
      W_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid && w_last)
          w_next = (B_LAT == 0) ? W_RESP : W_WAIT;
      end
      W_WAIT: begin
        if (lat == 4'(B_LAT - 1)) w_next = W_RESP;
      end
      W_RESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // write-side state, response status and counters
  always_ff @(posedge s_clk_wr or negedge s_rst_wr_n) begin
    if (!s_rst_wr_n) begin
      w_state   <= W_IDLE;
      lat       <= '0;
      b_bad     <= 1'b0;
      bid_q     <= '0;
      err_wlast <= 1'b0;
      wr_count  <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        bid_q <= bus.awid;
        b_bad <= 1'b0;
      end
      if (w_hs) begin
        b_bad <= b_bad | w_oor | w_bad;
        if (bus.wlast != w_last) err_wlast <= 1'b1;
      end
      if (w_hs && w_last)         lat <= '0;
      else if (w_state == W_WAIT) lat <= lat + 4'd1;
      if (b_hs && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
    end
  end

  // byte-lane writes; out-of-range beats are dropped
  always_ff @(posedge s_clk_wr) begin
    if (w_hs && !w_oor) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wstrb[i])
          mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // read FSM next state and handshake outputs
  always_comb begin
    r_next      = r_state;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        bus.arready = up;
        if (bus.arvalid && up) r_next = R_DATA;
      end
      R_DATA: begin
        bus.rvalid = 1'b1;
        if (bus.rready && rlast_q) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // read beat registers; same-cycle writes are seen next beat
  always_ff @(posedge s_clk_wr or negedge s_rst_wr_n) begin
    if (!s_rst_wr_n) begin
      r_state  <= R_IDLE;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
      rd_count <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) rid_q <= bus.arid;
      if (r_ld) begin
        rdata_q <= r_oor ? '0 : mem[r_idx];
        rresp_q <= (r_oor || r_bad) ? RESP_SLVERR
                                    : RESP_OKAY;
        rlast_q <= r_last;
      end
      if (r_hs && rlast_q && rd_count != 16'hFFFF)
        rd_count <= rd_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Randomized bench for the AXI memory responder with a word/byte model.
// A second instance with a 3-cycle B latency covers the delayed response.
module tb_axi_slave_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mem_if bus ();
  axi_mem_if bus3 ();

  logic [15:0] wr_count, rd_count, wr3, rd3;
  logic        err_wlast, err3;

  axi_slave_mem_responder dut (
    .s_clk_wr   (clk),
    .s_rst_wr_n (rst_n),
    .bus        (bus),
    .wr_count   (wr_count),
    .rd_count   (rd_count),
    .err_wlast  (err_wlast)
  );

  axi_slave_mem_responder #(.B_LAT(3)) dut3 (
    .s_clk_wr   (clk),
    .s_rst_wr_n (rst_n),
    .bus        (bus3),
    .wr_count   (wr3),
    .rd_count   (rd3),
    .err_wlast  (err3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // reference model: word array plus per-byte known mask
  logic [31:0] ref_mem [256];
  logic [3:0]  kb [256];
  int          exp_wr = 0;
  int          exp_rd = 0;
  bit          exp_err = 0;

  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  function automatic logic [31:0] beat_addr(
    input logic [31:0] a, input logic [1:0] bu, input int i);
    return (bu == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a >> 2) < 256;
  endfunction

  function automatic bit legal(input logic [1:0] bu,
                               input logic [2:0] sz);
    return (bu == 2'b00 || bu == 2'b01) && sz == 3'd2;
  endfunction

  task automatic wr_burst(input logic [31:0] a, input int len,
                          input logic [1:0] bu,
                          input logic [2:0] sz,
                          input logic [3:0] id, input int wl_at);
    int n;
    int stall;
    bit bad;
    logic [31:0] ba;
    @(negedge clk);
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    bus.awlen   = 8'(len);
    bus.awburst = bu;
    bus.awsize  = sz;
    bus.awid    = id;
    n = 0;
    while (!bus.awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_accept", 64'(n < 20), 1);
    @(posedge clk);
    #1 bus.awvalid = 1'b0;
    bad = !legal(bu, sz);
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      bus.wvalid = 1'b1;
      bus.wdata  = wd[i];
      bus.wstrb  = ws[i];
      bus.wlast  = (i == wl_at);
      chk("wready", bus.wready, 1);
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      ba = beat_addr(a, bu, i);
      if (in_range(ba)) begin
        for (int b = 0; b < 4; b++) begin
          if (ws[i][b]) begin
            ref_mem[ba[9:2]][8*b +: 8] = wd[i][8*b +: 8];
            kb[ba[9:2]][b] = 1'b1;
          end
        end
      end else begin
        bad = 1'b1;
      end
      if ((i == wl_at) != (i == len)) exp_err = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.bvalid && n < 40);
    chk("b_latency", n, 1);
    stall = $urandom_range(0, 2);
    for (int k = 0; k < stall; k++) begin
      chk("bresp_hold", bus.bresp, bad ? 2'b10 : 2'b00);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    chk("bvalid", bus.bvalid, 1);
    chk("bresp", bus.bresp, bad ? 2'b10 : 2'b00);
    chk("bid", bus.bid, id);
    @(posedge clk);
    #1 bus.bready = 1'b0;
    if (exp_wr < 65535) exp_wr++;
    @(negedge clk);
    chk("bvalid_drop", bus.bvalid, 0);
    chk("wr_count", wr_count, exp_wr);
    chk("err_wlast", err_wlast, exp_err);
  endtask

  task automatic rd_burst(input logic [31:0] a, input int len,
                          input logic [1:0] bu,
                          input logic [2:0] sz,
                          input logic [3:0] id, input int mode);
    int n;
    int i;
    int cyc;
    logic [31:0] ba, ed, mk;
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    bus.arlen   = 8'(len);
    bus.arburst = bu;
    bus.arsize  = sz;
    bus.arid    = id;
    n = 0;
    while (!bus.arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept", 64'(n < 20), 1);
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    i = 0;
    cyc = 0;
    while (i <= len && cyc < 200) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = (cyc % 2) == 1;
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      chk("rvalid", bus.rvalid, 1);
      ba = beat_addr(a, bu, i);
      if (in_range(ba)) begin
        ed = ref_mem[ba[9:2]];
        mk = {{8{kb[ba[9:2]][3]}}, {8{kb[ba[9:2]][2]}},
              {8{kb[ba[9:2]][1]}}, {8{kb[ba[9:2]][0]}}};
      end else begin
        ed = '0;
        mk = '1;
      end
      chk("rdata", bus.rdata & mk, ed & mk);
      chk("rresp", bus.rresp,
          (!in_range(ba) || !legal(bu, sz)) ? 2'b10 : 2'b00);
      chk("rlast", bus.rlast, 64'(i == len));
      chk("rid", bus.rid, id);
      if (bus.rready && bus.rvalid) begin
        @(posedge clk);
        #1 i++;
      end
    end
    chk("rd_beats", i, len + 1);
    bus.rready = 1'b0;
    if (exp_rd < 65535) exp_rd++;
    @(negedge clk);
    chk("rvalid_drop", bus.rvalid, 0);
    chk("rd_count", rd_count, exp_rd);
  endtask

  task automatic fill(input int len, input logic [31:0] base);
    for (int i = 0; i <= len; i++) begin
      wd[i] = base + 32'(i);
      ws[i] = 4'hF;
    end
  endtask

  initial begin
    int n;
    int len;
    logic [31:0] a;
    logic [1:0] bu;
    logic [2:0] sz;

    for (int w = 0; w < 256; w++) kb[w] = 4'h0;
    {bus.awvalid, bus.wvalid, bus.bready} = '0;
    {bus.arvalid, bus.rready, bus.wlast} = '0;
    {bus.awaddr, bus.awid, bus.awlen} = '0;
    {bus.awsize, bus.awburst} = '0;
    {bus.wdata, bus.wstrb} = '0;
    {bus.araddr, bus.arid, bus.arlen} = '0;
    {bus.arsize, bus.arburst} = '0;
    {bus3.awvalid, bus3.wvalid, bus3.bready} = '0;
    {bus3.arvalid, bus3.rready, bus3.wlast} = '0;
    {bus3.awaddr, bus3.awid, bus3.awlen} = '0;
    {bus3.awsize, bus3.awburst} = '0;
    {bus3.wdata, bus3.wstrb} = '0;
    {bus3.araddr, bus3.arid, bus3.arlen} = '0;
    {bus3.arsize, bus3.arburst} = '0;

    repeat (2) @(negedge clk);
    chk("rst_awready", bus.awready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_counts", {wr_count, rd_count}, 0);
    chk("rst_err", err_wlast, 0);
    rst_n = 1'b1;
    #1 chk("rel_awready", bus.awready, 0);
    @(posedge clk);
    #1;
    chk("up_awready", bus.awready, 1);
    chk("up_arready", bus.arready, 1);

    // single write and read back
    fill(0, 32'hABCD1234);
    wr_burst(32'h100, 0, 2'b01, 3'd2, 4'h0, 0);
    rd_burst(32'h100, 0, 2'b01, 3'd2, 4'h0, 0);

    // INCR burst, read with toggling rready
    fill(3, 32'd1);
    wr_burst(32'h40, 3, 2'b01, 3'd2, 4'h3, 3);
    rd_burst(32'h40, 3, 2'b01, 3'd2, 4'h3, 1);

    // byte strobes
    fill(0, 32'hFFFFFFFF);
    wr_burst(32'h80, 0, 2'b01, 3'd2, 4'h1, 0);
    wd[0] = 32'h11223344;
    ws[0] = 4'b0101;
    wr_burst(32'h80, 0, 2'b01, 3'd2, 4'h1, 0);
    chk("strobe_model", ref_mem[32], 32'hFF22FF44);
    rd_burst(32'h80, 0, 2'b01, 3'd2, 4'h1, 0);

    // out of range: word 0 must survive
    fill(0, 32'h5A5A0000);
    wr_burst(32'h0, 0, 2'b01, 3'd2, 4'h2, 0);
    fill(0, 32'hDEAD0000);
    wr_burst(32'h400, 0, 2'b01, 3'd2, 4'h2, 0);
    rd_burst(32'h400, 0, 2'b01, 3'd2, 4'h2, 0);
    rd_burst(32'h0, 0, 2'b01, 3'd2, 4'h2, 0);

    // early wlast: burst still runs 4 beats
    fill(3, 32'h700);
    wr_burst(32'hC0, 3, 2'b01, 3'd2, 4'h7, 1);
    rd_burst(32'hC0, 3, 2'b01, 3'd2, 4'h7, 2);

    // B latency of 3 on the second instance
    @(negedge clk);
    bus3.awvalid = 1'b1;
    bus3.awaddr  = 32'h40;
    bus3.awlen   = 8'd3;
    bus3.awsize  = 3'd2;
    bus3.awburst = 2'b01;
    bus3.awid    = 4'h5;
    n = 0;
    while (!bus3.awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw3_accept", 64'(n < 20), 1);
    @(posedge clk);
    #1 bus3.awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus3.wvalid = 1'b1;
      bus3.wdata  = 32'(i);
      bus3.wstrb  = 4'hF;
      bus3.wlast  = (i == 1);
      chk("w3_ready", bus3.wready, 1);
      @(posedge clk);
      #1 {bus3.wvalid, bus3.wlast} = 2'b00;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus3.bvalid && n < 40);
    chk("b3_latency", n, 4);
    chk("b3_resp", bus3.bresp, 2'b00);
    chk("b3_bid", bus3.bid, 4'h5);
    chk("b3_err", err3, 1);
    bus3.bready = 1'b1;
    @(posedge clk);
    #1 bus3.bready = 1'b0;
    @(negedge clk);
    chk("b3_count", wr3, 1);

    // randomized bursts with read-back
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(0, 7);
      a = ($urandom_range(0, 9) == 0)
        ? 32'($urandom_range(250, 260)) << 2
        : 32'($urandom_range(0, 255)) << 2;
      case ($urandom_range(0, 9))
        0:       bu = 2'b00;
        1:       bu = 2'($urandom_range(2, 3));
        default: bu = 2'b01;
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      for (int i = 0; i <= len; i++) begin
        wd[i] = $urandom;
        ws[i] = ($urandom_range(0, 3) == 0)
              ? 4'($urandom) : 4'hF;
      end
      wr_burst(a, len, bu, sz, 4'($urandom),
               ($urandom_range(0, 9) == 0)
                 ? $urandom_range(0, len) : len);
      rd_burst(a, len, bu, sz, 4'($urandom), 2);
    end

    // reset in the middle of a read burst
    fill(3, 32'hCAFE0000);
    wr_burst(32'h200, 3, 2'b01, 3'd2, 4'h9, 3);
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr  = 32'h200;
    bus.arlen   = 8'd3;
    bus.arsize  = 3'd2;
    bus.arburst = 2'b01;
    bus.arid    = 4'h9;
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    n = 0;
    while (n < 2) begin
      @(negedge clk);
      chk("mid_rdata", bus.rdata, 32'hCAFE0000 + 32'(n));
      @(posedge clk);
      #1 n++;
    end
    @(negedge clk);
    bus.rready = 1'b0;
    rst_n = 1'b0;
    exp_wr = 0;
    exp_rd = 0;
    exp_err = 1'b0;
    #1;
    chk("mid_rvalid", bus.rvalid, 0);
    chk("mid_arready", bus.arready, 0);
    chk("mid_rd_count", rd_count, 0);
    chk("mid_err", err_wlast, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rel_arready", bus.arready, 0);
    @(posedge clk);
    #1 chk("mid_up_arready", bus.arready, 1);
    rd_burst(32'h200, 3, 2'b01, 3'd2, 4'h4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
